// File: rtl/vid_axis_pkg.sv
// Shared types for the video-to-AXI-Stream bridge: FSM states, frame counter
// width and the default-width FIFO beat layout {tuser, tlast, tdata}.
package vid_axis_pkg;

  localparam int FCNT_W = 16;
  localparam int PIX_DW = 24;
  localparam int PIX_UW = 1;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DROP     = 2'd2
  } state_t;

  typedef struct packed {
    logic [PIX_UW-1:0] tuser;
    logic              tlast;
    logic [PIX_DW-1:0] tdata;
  } entry_t;

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle; m drives the stream, s consumes it.
interface axis_if #(
  parameter int DW = 24,
  parameter int UW = 1
);
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic [UW-1:0]   tuser;
  logic [DW/8-1:0] tkeep;
  logic [DW/8-1:0] tstrb;
  logic [3:0]      tdest;
  logic [3:0]      tid;

  modport m (output tdata, tvalid, tlast, tuser, tkeep, tstrb, tdest, tid, input tready);
  modport s (input tdata, tvalid, tlast, tuser, tkeep, tstrb, tdest, tid, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; rd_data shows the head entry
// whenever empty is low. Writes when full and reads when empty are ignored.
module sync_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vid_to_axis.sv
// Converts a vs/de video stream to AXI4-Stream via a one-entry stage and a FWFT
// FIFO; a pixel sampled at cycle N is valid at N+2. A full FIFO drops the frame.
module vid_to_axis
  import vid_axis_pkg::*;
#(
  parameter int DW    = 24,
  parameter int UW    = 1,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [DW-1:0]     vid_data,
  axis_if.m                 m,
  output logic              ovf_err,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef struct packed {
    logic [UW-1:0] tuser;
    logic          tlast;
    logic [DW-1:0] tdata;
  } beat_t;

  localparam int EW = $bits(beat_t);

  state_t                 state;
  logic                   vs_d;
  logic                   sof_pend;
  logic                   stg_vld;
  logic                   stg_sof;
  logic [DW-1:0]          stg_dat;
  logic                   vs_rise;
  logic                   ovf;
  logic                   wr_en;
  logic                   load;
  logic                   rd_en;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count_unused;
  beat_t                  wr_beat;
  beat_t                  rd_beat;

  assign vs_rise = vid_vs & ~vs_d;
  // Full blocks the write even if a pop happens this cycle, so tready never
  // reaches the write decision.
  assign ovf     = stg_vld & fifo_full;
  assign wr_en   = stg_vld & ~fifo_full;
  assign load    = (state == ACTIVE) & vid_de & ~ovf;

  always_comb begin
    wr_beat          = '0;
    wr_beat.tuser[0] = stg_sof;
    wr_beat.tlast    = ~vid_de | vs_rise;
    wr_beat.tdata    = stg_dat;
  end

  sync_fifo_fwft #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_data (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign rd_en    = ~fifo_empty & m.tready;
  assign m.tvalid = ~fifo_empty;
  assign m.tdata  = fifo_empty ? '0 : rd_beat.tdata;
  assign m.tlast  = fifo_empty ? 1'b0 : rd_beat.tlast;
  assign m.tuser  = fifo_empty ? '0 : rd_beat.tuser;
  assign m.tkeep  = '1;
  assign m.tstrb  = '1;
  assign m.tdest  = '0;
  assign m.tid    = '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= WAIT_SOF;
      vs_d       <= 1'b0;
      sof_pend   <= 1'b0;
      stg_vld    <= 1'b0;
      stg_sof    <= 1'b0;
      stg_dat    <= '0;
      ovf_err    <= 1'b0;
      ovf_sticky <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vs_d    <= vid_vs;
      ovf_err <= ovf;
      stg_vld <= load;
      if (load) begin
        stg_dat <= vid_data;
        stg_sof <= sof_pend | vs_rise;
      end
      if (ovf) ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
      if (wr_en && stg_sof) frame_cnt <= frame_cnt + FCNT_W'(1);

      case (state)
        WAIT_SOF, DROP: begin
          if (vs_rise) begin
            state    <= ACTIVE;
            sof_pend <= 1'b1;
          end
        end
        ACTIVE: begin
          // A new frame starting in the overflow cycle keeps the bridge active.
          if (ovf && !vs_rise) state <= DROP;
          else if (load) sof_pend <= 1'b0;
          else if (vs_rise) sof_pend <= 1'b1;
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: doc/vid_to_axis.md
VID_TO_AXIS -- requirements
Module: vid_to_axis

Interface
REQ-001 Parameter DW, default 24: pixel data width in bits (multiple of 8).
REQ-002 Parameter UW, default 1: tuser width; bit 0 carries start-of-frame (SOF).
REQ-003 Parameter DEPTH, default 16: output FIFO entries (power of 2, at least 4).
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port vid_vs, input, 1: vertical sync, active-high.
REQ-007 Port vid_de, input, 1: data enable; one pixel per cycle when high.
REQ-008 Port vid_data, input, DW: pixel value.
REQ-009 Port m, axis_if.m, interface: output stream. Fields driven: tdata, tvalid, tlast, tuser. tkeep and tstrb are all ones. tdest and tid are zero.
REQ-010 Port ovf_err, output, 1: one-cycle pulse on the first dropped pixel.
REQ-011 Port ovf_sticky, output, 1: latched overflow flag.
REQ-012 Port ovf_clr, input, 1: clears ovf_sticky.
REQ-013 Port frame_cnt, output, 16: count of SOF beats written to the FIFO; wraps 0xFFFF to 0.

Function
REQ-014 Rising edge of vid_vs is detected against a one-cycle registered copy of vid_vs.
REQ-015 State machine, reset state WAIT_SOF:
- WAIT_SOF: pixels are ignored. On a vs rising edge, set sof_pend=1 and go to ACTIVE.
- ACTIVE: pixels are captured. On overflow, go to DROP.
- DROP: pixels are discarded. On a vs rising edge, set sof_pend=1 and go to ACTIVE.
REQ-016 Stage register, 1 entry: in ACTIVE, each vid_de=1 pixel is loaded into the stage register with tuser[0]=sof_pend. sof_pend clears on that load.
REQ-017 The staged pixel is written to the FIFO on the next cycle, with:
- tlast=1 if vid_de=0 or a vs rising edge occurs that cycle;
- tlast=0 otherwise.
REQ-018 Latency: a pixel sampled with vid_de at cycle N appears on m.tvalid at cycle N+2 when the FIFO is empty.
REQ-019 FIFO is first-word-fall-through. m.tvalid = not empty. A pop occurs when m.tvalid & m.tready.
REQ-020 A FIFO write is blocked whenever count==DEPTH, even if a pop occurs the same cycle. This keeps tready out of the write path.
REQ-021 A blocked write is an overflow:
- the staged pixel is discarded;
- ovf_err pulses;
- ovf_sticky sets;
- state goes to DROP;
- no tlast is emitted for the truncated line.
REQ-022 ovf_sticky: set wins over ovf_clr when both occur in the same cycle.
REQ-023 A vs rising edge in ACTIVE with a staged pixel forces tlast=1 on that pixel. The new frame's first pixel carries tuser[0]=1.
REQ-024 Output fields hold stable while m.tvalid=1 and m.tready=0.
REQ-025 frame_cnt increments when an entry with tuser[0]=1 is written to the FIFO.

Reset
REQ-026 On rstn low, asynchronously:
- state=WAIT_SOF;
- FIFO is empty;
- stage register and sof_pend are cleared;
- m.tvalid, m.tlast, m.tuser, ovf_err, ovf_sticky and frame_cnt are 0;
- m.tdata is 0.
REQ-027 Reset mid-line discards all buffered pixels. After release, output resumes only after the next vs rising edge.

Structure
REQ-028 Package vid_axis_pkg holds:
- state enum (WAIT_SOF, ACTIVE, DROP);
- FIFO entry struct {tuser, tlast, tdata};
- FCNT_W=16.
REQ-029 One sub-module, sync_fifo_fwft, parameterised by entry width and DEPTH. It provides full, empty and count outputs.

Verification
REQ-030 4x2 frame (vs pulse, two lines of 4 DE pixels, data 1..8), tready=1:
- 8 beats, data 1..8;
- tuser on beat 1 only;
- tlast on beats 4 and 8;
- frame_cnt=1;
- first tvalid 2 cycles after the first DE.
REQ-031 DEPTH=16, tready=0, one 20-pixel line:
- 16 entries stored;
- ovf_err pulses once, on pixel 17;
- ovf_sticky=1, state DROP, pixels 18..20 discarded.
Then raise tready: 16 beats with no tlast. The next frame starts with tuser=1.
REQ-032 DE pixels after reset but before any vs edge produce no beats, and frame_cnt stays 0.
REQ-033 vs rising edge during pixel 3 of a line: pixel 3 is emitted with tlast=1, and the next DE pixel is emitted with tuser=1.
REQ-034 Random tready toggling over 3 frames of 8x4 pixels, no overflow: the output sequence equals the input sequence, and frame_cnt=3.
REQ-035 rstn low at pixel 5 of line 1: tvalid=0 within the reset cycle, and no beats appear until the next vs edge followed by DE.
